// File: rtl/sram_like_arbiter_pkg.sv
// sram_like_arbiter_pkg
// Shared definitions for the SRAM-like two-master arbiter: master IDs,
// grant-state encodings, transfer size encodings and a small helper.
// No ports (package).
package sram_like_arbiter_pkg;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef enum logic [1:0] {
    GNT_IDLE   = 2'd0,
    GNT_LOCK_I = 2'd1,
    GNT_LOCK_D = 2'd2
  } gnt_state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Lock state that holds the grant on the given master.
  function automatic gnt_state_e lock_state(input logic id);
    return (id == ID_DATA) ? GNT_LOCK_D : GNT_LOCK_I;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if
// One SRAM-like request/response port.
//   req, wr, size, wstrb, addr, wdata : request fields (master -> slave)
//   addr_ok                           : request accepted this cycle
//   data_ok, rdata                    : response strobe and read data
// Modports: master drives the request, slave drives the responses.
interface sram_like_arbiter_if;
  import sram_like_arbiter_pkg::*;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/sram_like_arbiter_id_fifo.sv
// sram_like_arbiter_id_fifo (id_fifo)
// In-order FIFO of 1-bit master IDs for accepted-but-unanswered requests.
//   clk, reset  : clock, synchronous active-high reset
//   push_i      : enqueue push_id_i (ignored when full)
//   push_id_i   : master ID to enqueue
//   pop_i       : dequeue head (ignored when empty)
//   head_id_o   : ID at the head
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module sram_like_arbiter_id_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic push_id_i,
  input  logic pop_i,
  output logic head_id_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] ids_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign head_id_o = ids_q[rd_ptr_q];
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    // push+pop together leaves occupancy unchanged
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) ids_q[wr_ptr_q] <= push_id_i;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
// Arbitrates a fetch master (inst_if) and a MEM-stage master (data_if)
// onto one shared SRAM-like slave port (mem_if) with zero added latency.
//   clk, reset : clock, synchronous active-high reset
//   inst_if    : fetch-master port (slave modport)
//   data_if    : MEM-stage master port (slave modport)
//   mem_if     : shared slave port (master modport)
// Parameter OST_DEPTH: max accepted-but-unanswered requests (power of two, >= 2).
// Macro ARB_ROUND_ROBIN_EN: when defined, the idle grant favours the master
// not granted at the last accepted handshake; otherwise data beats fetch.
//
// state      | meaning
// GNT_IDLE   | grant chosen combinationally from current requests
// GNT_LOCK_I | request stalled by slave, grant held on fetch master
// GNT_LOCK_D | request stalled by slave, grant held on data master
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OST_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  sram_like_arbiter_if.slave  inst_if,
  sram_like_arbiter_if.slave  data_if,
  sram_like_arbiter_if.master mem_if
);

  gnt_state_e state_q, state_d;
  logic       prefer_data;
  logic       gnt_id;
  logic       gnt_req;
  logic       handshake;
  logic       pop;
  logic       fifo_full, fifo_empty, head_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic favour_data_q, favour_data_d;

  always_comb begin
    favour_data_d = favour_data_q;
    if (handshake) favour_data_d = (gnt_id == ID_INST);
  end

  always_ff @(posedge clk) begin
    if (reset) favour_data_q <= 1'b1;
    else       favour_data_q <= favour_data_d;
  end

  assign prefer_data = favour_data_q;
`else
  assign prefer_data = 1'b1;
`endif

  always_comb begin
    gnt_id = ID_INST;
    case (state_q)
      GNT_LOCK_I: gnt_id = ID_INST;
      GNT_LOCK_D: gnt_id = ID_DATA;
      default:    gnt_id = (data_if.req && (!inst_if.req || prefer_data)) ? ID_DATA : ID_INST;
    endcase
  end

  assign gnt_req = (gnt_id == ID_DATA) ? data_if.req : inst_if.req;

  // Full blocks the request on registered occupancy only, so a same-cycle
  // response cannot reopen it combinationally.
  assign mem_if.req   = gnt_req & ~fifo_full & ~reset;
  assign mem_if.wr    = (gnt_id == ID_DATA) ? data_if.wr    : inst_if.wr;
  assign mem_if.size  = (gnt_id == ID_DATA) ? data_if.size  : inst_if.size;
  assign mem_if.wstrb = (gnt_id == ID_DATA) ? data_if.wstrb : inst_if.wstrb;
  assign mem_if.addr  = (gnt_id == ID_DATA) ? data_if.addr  : inst_if.addr;
  assign mem_if.wdata = (gnt_id == ID_DATA) ? data_if.wdata : inst_if.wdata;

  assign handshake       = mem_if.req & mem_if.addr_ok;
  assign inst_if.addr_ok = handshake & (gnt_id == ID_INST);
  assign data_if.addr_ok = handshake & (gnt_id == ID_DATA);

  // Responses with nothing outstanding are dropped.
  assign pop             = mem_if.data_ok & ~fifo_empty & ~reset;
  assign inst_if.data_ok = pop & (head_id == ID_INST);
  assign data_if.data_ok = pop & (head_id == ID_DATA);
  assign inst_if.rdata   = mem_if.rdata;
  assign data_if.rdata   = mem_if.rdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      GNT_IDLE:   if (mem_if.req && !mem_if.addr_ok) state_d = lock_state(gnt_id);
      GNT_LOCK_I: if (handshake || !inst_if.req) state_d = GNT_IDLE;
      GNT_LOCK_D: if (handshake || !data_if.req) state_d = GNT_IDLE;
      default:    state_d = GNT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= GNT_IDLE;
    else       state_q <= state_d;
  end

  sram_like_arbiter_id_fifo #(.DEPTH(OST_DEPTH)) id_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (handshake),
    .push_id_i (gnt_id),
    .pop_i     (pop),
    .head_id_o (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_like_arbiter_if inst_bus ();
  sram_like_arbiter_if data_bus ();
  sram_like_arbiter_if mem_bus ();

  sram_like_arbiter #(.OST_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .inst_if (inst_bus),
    .data_if (data_bus),
    .mem_if  (mem_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ireq, input logic dreq, input logic aok,
                       input logic dok, input logic [31:0] rd);
    inst_bus.req    = ireq;
    data_bus.req    = dreq;
    mem_bus.addr_ok = aok;
    mem_bus.data_ok = dok;
    mem_bus.rdata   = rd;
  endtask

  task automatic chk_strobes(input string tag, input logic mreq, input logic iaok,
                             input logic daok, input logic idok, input logic ddok);
    chk1({tag, ".mem_req"}, mem_bus.req, mreq);
    chk1({tag, ".inst_addr_ok"}, inst_bus.addr_ok, iaok);
    chk1({tag, ".data_addr_ok"}, data_bus.addr_ok, daok);
    chk1({tag, ".inst_data_ok"}, inst_bus.data_ok, idok);
    chk1({tag, ".data_data_ok"}, data_bus.data_ok, ddok);
  endtask

  // in_bits = {inst_req, data_req, mem_addr_ok, mem_data_ok}
  // exp_bits = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}
  typedef struct {
    logic [3:0]  in_bits;
    logic [31:0] rdata;
    logic [4:0]  exp_bits;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[9];

  // Reference model: outstanding IDs as a queue, lock owner as an int.
  int m_q[$];
  int m_lock;
  bit m_fav_data;

  task automatic model_reset();
    m_q.delete();
    m_lock     = -1;
    m_fav_data = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 32'h0);
    inst_bus.wr = 0; inst_bus.size = SIZE_WORD; inst_bus.wstrb = 4'hf;
    inst_bus.addr = 32'h1c00_0000; inst_bus.wdata = 32'h0;
    data_bus.wr = 0; data_bus.size = SIZE_WORD; data_bus.wstrb = 4'hf;
    data_bus.addr = 32'h0000_1000; data_bus.wdata = 32'h0;

    vecs[0] = '{4'b1110, 32'h0000_0000, 5'b10100, 32'h0000_1000};
    vecs[1] = '{4'b1010, 32'h0000_0000, 5'b11000, 32'h1c00_0000};
    vecs[2] = '{4'b1111, 32'hAAAA_5555, 5'b00001, 32'h0};
    vecs[3] = '{4'b0101, 32'h1234_5678, 5'b10010, 32'h0000_1000};
    vecs[4] = '{4'b1100, 32'h0000_0000, 5'b10000, 32'h0000_1000};
    vecs[5] = '{4'b1010, 32'h0000_0000, 5'b00000, 32'h0};
    vecs[6] = '{4'b1010, 32'h0000_0000, 5'b11000, 32'h1c00_0000};
    vecs[7] = '{4'b0001, 32'h0000_0005, 5'b00010, 32'h0};
    vecs[8] = '{4'b0001, 32'h0000_DEAD, 5'b00000, 32'h0};

    repeat (2) @(negedge clk);
    // Outputs stay quiet during reset even with every input active.
    drive(1, 1, 1, 1, 32'hFFFF_FFFF);
    #1 chk_strobes("in_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0, 32'h0);

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      @(negedge clk);
      drive(vecs[i].in_bits[3], vecs[i].in_bits[2], vecs[i].in_bits[1],
            vecs[i].in_bits[0], vecs[i].rdata);
      #1;
      chk_strobes(tag, vecs[i].exp_bits[4], vecs[i].exp_bits[3], vecs[i].exp_bits[2],
                  vecs[i].exp_bits[1], vecs[i].exp_bits[0]);
      if (vecs[i].exp_bits[4]) chk32({tag, ".mem_addr"}, mem_bus.addr, vecs[i].exp_addr);
      if (vecs[i].exp_bits[0]) chk32({tag, ".data_rdata"}, data_bus.rdata, vecs[i].rdata);
      if (vecs[i].exp_bits[1]) chk32({tag, ".inst_rdata"}, inst_bus.rdata, vecs[i].rdata);
    end

    // Fetch stalled in LOCK_I while data_req rises.
    inst_bus.addr = 32'h1c00_0040;
    data_bus.addr = 32'h0000_2000;
    @(negedge clk); drive(1, 0, 0, 0, 32'h0);
    #1 chk1("lock_i.c0.mem_req", mem_bus.req, 1'b1);
    chk32("lock_i.c0.mem_addr", mem_bus.addr, 32'h1c00_0040);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); drive(1, 1, 0, 0, 32'h0);
      #1 chk32($sformatf("lock_i.c%0d.mem_addr", c), mem_bus.addr, 32'h1c00_0040);
      chk1($sformatf("lock_i.c%0d.data_addr_ok", c), data_bus.addr_ok, 1'b0);
    end
    @(negedge clk); drive(1, 1, 1, 0, 32'h0);
    #1 chk_strobes("lock_i.acc", 1, 1, 0, 0, 0);
    chk32("lock_i.acc.mem_addr", mem_bus.addr, 32'h1c00_0040);
    @(negedge clk); drive(0, 1, 1, 0, 32'h0);
    #1 chk_strobes("lock_i.dacc", 1, 0, 1, 0, 0);
    chk32("lock_i.dacc.mem_addr", mem_bus.addr, 32'h0000_2000);
    @(negedge clk); drive(0, 0, 0, 1, 32'h1111_1111);
    #1 chk_strobes("lock_i.r0", 0, 0, 0, 1, 0);
    @(negedge clk); drive(0, 0, 0, 1, 32'h2222_2222);
    #1 chk_strobes("lock_i.r1", 0, 0, 0, 0, 1);

    // Reset with one outstanding fetch, then a stray response.
    @(negedge clk); drive(1, 0, 1, 0, 32'h0);
    #1 chk1("rst_mid.acc", inst_bus.addr_ok, 1'b1);
    @(negedge clk); reset = 1'b1; drive(0, 0, 0, 1, 32'h3333_3333);
    #1 chk_strobes("rst_mid.during", 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0; drive(0, 0, 0, 1, 32'h4444_4444);
    #1 chk_strobes("rst_mid.stray", 0, 0, 0, 0, 0);

    // Randomized run against the queue-based reference model.
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit ireq, dreq, aok, dok, rst_now, full, e_mreq, e_hs, e_pop;
      int owner, oreq, head;
      logic [31:0] rd;
      @(negedge clk);
      rst_now = ($urandom_range(0, 99) == 0);
      ireq = ($urandom_range(0, 9) < 7);
      dreq = ($urandom_range(0, 9) < 5);
      aok  = $urandom_range(0, 1) == 1;
      dok  = ($urandom_range(0, 9) < 4);
      rd   = $urandom;
      reset = rst_now;
      inst_bus.wr = $urandom_range(0, 1) == 1; inst_bus.size = 2'($urandom_range(0, 2));
      inst_bus.wstrb = 4'($urandom); inst_bus.addr = $urandom; inst_bus.wdata = $urandom;
      data_bus.wr = $urandom_range(0, 1) == 1; data_bus.size = 2'($urandom_range(0, 2));
      data_bus.wstrb = 4'($urandom); data_bus.addr = $urandom; data_bus.wdata = $urandom;
      drive(ireq, dreq, aok, dok, rd);
      #1;
      if (rst_now) begin
        chk_strobes("rnd.reset", 0, 0, 0, 0, 0);
        model_reset();
        continue;
      end
      full = (m_q.size() == DEPTH);
      if (m_lock >= 0)                        owner = m_lock;
      else if (dreq && (!ireq || m_fav_data)) owner = 1;
      else if (ireq)                          owner = 0;
      else                                    owner = -1;
      oreq   = (owner == 1) ? int'(dreq) : (owner == 0) ? int'(ireq) : 0;
      e_mreq = (oreq != 0) && !full;
      e_hs   = e_mreq && aok;
      e_pop  = dok && (m_q.size() > 0);
      head   = e_pop ? m_q[0] : -1;
      chk_strobes("rnd", e_mreq, e_hs && owner == 0, e_hs && owner == 1,
                  e_pop && head == 0, e_pop && head == 1);
      chk32("rnd.inst_rdata", inst_bus.rdata, rd);
      chk32("rnd.data_rdata", data_bus.rdata, rd);
      if (e_mreq) begin
        chk32("rnd.mem_addr", mem_bus.addr, owner == 1 ? data_bus.addr : inst_bus.addr);
        chk32("rnd.mem_wdata", mem_bus.wdata, owner == 1 ? data_bus.wdata : inst_bus.wdata);
        chk1("rnd.mem_wr", mem_bus.wr, owner == 1 ? data_bus.wr : inst_bus.wr);
        chk32("rnd.mem_size", {30'b0, mem_bus.size},
              {30'b0, (owner == 1 ? data_bus.size : inst_bus.size)});
        chk32("rnd.mem_wstrb", {28'b0, mem_bus.wstrb},
              {28'b0, (owner == 1 ? data_bus.wstrb : inst_bus.wstrb)});
      end
      if (e_pop) void'(m_q.pop_front());
      if (e_hs) m_q.push_back(owner);
      if (m_lock < 0) begin
        if (e_mreq && !aok) m_lock = owner;
      end else if (e_hs || oreq == 0) begin
        m_lock = -1;
      end
`ifdef ARB_ROUND_ROBIN_EN
      if (e_hs) m_fav_data = (owner == 0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
